// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the write port of an async FIFO between N lanes.
// Bursts of up to BURST_MAX words per grant, throttled by full_w/space_count.
module fifo_wr_arbiter #(
   parameter int N         = 4,
   parameter int DW        = 32,
   parameter int BURST_MAX = 8,
   parameter int CW        = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    req,
   input  logic [N*DW-1:0] data_in,
   output logic [N-1:0]    ack,
   output logic [N-1:0]    grant,
   output logic            busy,
   output logic            en_w,
   output logic [DW-1:0]   data_w,
   input  logic            full_w,
   input  logic [CW-1:0]   space_count
);

   localparam int PW = $clog2(N);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t          state, state_n;
   logic [N-1:0]    grant_n;
   logic [PW-1:0]   ptr, ptr_n;
   logic [7:0]      beats, beats_n;
   logic            en_n, busy_n;
   logic [DW-1:0]   data_n;
   logic [PW-1:0]   owner, winner;
   logic            space_ok, accept;
   logic [DW-1:0]   lane;

   always_comb begin
      owner = '0;
      for (int i = 0; i < N; i++)
         if (grant[i]) owner = PW'(i);
   end

   always_comb begin
      winner = ptr;
      for (int k = N - 1; k >= 0; k--)
         if (req[(int'(ptr) + k) % N])
            winner = PW'((int'(ptr) + k) % N);
   end

   // a registered write not yet visible in space_count still needs a slot
   assign space_ok = !full_w && (space_count > CW'(en_w));
   assign lane     = data_in[int'(owner)*DW +: DW];
   assign accept   = (state == GRANT) && req[owner] && space_ok && !rst;
   assign ack      = accept ? grant : '0;

   always_comb begin
      state_n = state;
      grant_n = grant;
      ptr_n   = ptr;
      beats_n = beats;
      en_n    = 1'b0;
      data_n  = data_w;
      unique case (state)
         IDLE: begin
            if (|req) begin
               state_n         = GRANT;
               grant_n         = '0;
               grant_n[winner] = 1'b1;
               beats_n         = '0;
            end
         end
         GRANT: begin
            if (accept) begin
               en_n    = 1'b1;
               data_n  = lane;
               beats_n = beats + 8'd1;
            end
            if ((!req[owner] && space_ok) ||
                (accept && beats == 8'(BURST_MAX - 1))) begin
               state_n = IDLE;
               grant_n = '0;
               ptr_n   = (owner == PW'(N - 1)) ? '0 : owner + 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
      busy_n = (state_n == GRANT);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         grant  <= '0;
         ptr    <= '0;
         beats  <= '0;
         busy   <= 1'b0;
         en_w   <= 1'b0;
         data_w <= '0;
      end else begin
         state  <= state_n;
         grant  <= grant_n;
         ptr    <= ptr_n;
         beats  <= beats_n;
         busy   <= busy_n;
         en_w   <= en_n;
         data_w <= data_n;
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomised scoreboard bench for fifo_wr_arbiter against a
// transaction-level model of grants, bursts and FIFO occupancy.
module tb_fifo_wr_arbiter;

   localparam int N     = 4;
   localparam int DW    = 32;
   localparam int BM    = 8;
   localparam int CW    = 8;
   localparam int DEPTH = 16;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req;
   logic [N*DW-1:0] data_in;
   logic [N-1:0]    ack, grant;
   logic            busy, en_w, full_w;
   logic [DW-1:0]   data_w;
   logic [CW-1:0]   space_count;

   always #5 clk = ~clk;

   fifo_wr_arbiter #(.N(N), .DW(DW), .BURST_MAX(BM), .CW(CW)) dut (
      .clk(clk), .rst(rst), .req(req), .data_in(data_in),
      .ack(ack), .grant(grant), .busy(busy), .en_w(en_w),
      .data_w(data_w), .full_w(full_w), .space_count(space_count)
   );

   int checks = 0;
   int passes = 0;

   logic [DW-1:0] exp_q [$];
   logic [DW-1:0] lane_q [N][$];

   int m_owner = -1;
   int m_beats = 0;
   int m_ptr   = 0;
   bit m_en    = 1'b0;

   bit fifo_mode = 1'b0;
   int occ = 0;
   int drain_pct = 0;
   int force_full_pct = 0;
   logic [CW-1:0] fix_space = 8'd16;
   int seq = 0;

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   always @(negedge clk) begin
      if (en_w === 1'b1) begin
         chk("write expected", 64'(exp_q.size() != 0), 64'd1);
         if (exp_q.size() != 0) chk("data_w", data_w, exp_q.pop_front());
      end
   end

   task automatic apply();
      for (int i = 0; i < N; i++) begin
         req[i] = lane_q[i].size() > 0;
         data_in[i*DW +: DW] = (lane_q[i].size() > 0) ? lane_q[i][0] : '0;
      end
      if (fifo_mode) begin
         space_count = CW'(DEPTH - occ);
         full_w = (occ >= DEPTH) ||
                  (force_full_pct > 0 && $urandom_range(99) < force_full_pct);
      end else begin
         space_count = fix_space;
         full_w = 1'b0;
      end
   endtask

   task automatic step();
      logic [N-1:0] eack;
      bit sok, acc, en_now;
      @(negedge clk);
      chk("grant", grant, (m_owner < 0) ? 0 : (1 << m_owner));
      chk("busy", busy, m_owner >= 0);
      chk("en_w", en_w, m_en);
      sok = !full_w && (int'(space_count) > int'(m_en));
      en_now = m_en;
      eack = '0;
      if (rst) begin
         m_owner = -1; m_beats = 0; m_ptr = 0; m_en = 0;
      end else if (m_owner < 0) begin
         m_en = 0;
         for (int k = 0; k < N && m_owner < 0; k++)
            if (req[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
         m_beats = 0;
      end else begin
         acc = req[m_owner] && sok;
         m_en = acc;
         if (acc) begin
            eack[m_owner] = 1'b1;
            exp_q.push_back(lane_q[m_owner].pop_front());
            m_beats++;
         end
         if ((!req[m_owner] && sok) || (acc && m_beats == BM)) begin
            m_ptr = (m_owner + 1) % N;
            m_owner = -1;
         end
      end
      chk("ack", ack, eack);
      if (fifo_mode) begin
         occ += int'(en_now);
         if (occ > 0 && $urandom_range(99) < drain_pct) occ--;
      end
      @(posedge clk);
      #1;
      apply();
   endtask

   task automatic run(int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic push(int l, int n);
      for (int i = 0; i < n; i++) begin
         lane_q[l].push_back({8'(l), 24'(seq)});
         seq++;
      end
   endtask

   initial begin
      bit seen;
      rst = 1'b1;
      req = '0;
      data_in = '0;
      full_w = 1'b0;
      space_count = 8'd16;
      repeat (2) @(posedge clk);
      #1;
      step();
      chk("reset data_w", data_w, 0);
      rst = 1'b0;
      apply();

      // single requester, directed words
      lane_q[0].push_back(32'd1001);
      lane_q[0].push_back(32'd1002);
      lane_q[0].push_back(32'd1003);
      apply();
      run(8);

      // all four competing continuously
      for (int l = 0; l < N; l++) push(l, 40);
      apply();
      run(200);

      // backpressure: FIFO stuck with two free entries
      fifo_mode = 1'b1;
      occ = 14;
      drain_pct = 0;
      push(1, 5);
      apply();
      run(10);
      drain_pct = 100;
      run(15);

      // in-flight accounting: one free entry
      occ = 15;
      drain_pct = 0;
      push(2, 3);
      apply();
      run(6);
      drain_pct = 100;
      run(12);

      // reset in the middle of a burst
      fifo_mode = 1'b0;
      push(0, 8);
      apply();
      for (int t = 0; t < 20 && m_beats != 3; t++) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      lane_q[0].delete();
      push(1, 2);
      push(2, 2);
      apply();
      run(12);

      // fairness: lane 3 joins while lane 0 streams
      push(0, 30);
      apply();
      run(3);
      push(3, 2);
      apply();
      seen = 1'b0;
      for (int t = 0; t < BM + 2 && !seen; t++) begin
         step();
         seen = grant[3];
      end
      chk("fairness grant", 64'(seen), 64'd1);
      run(40);

      // randomised traffic against a draining FIFO
      fifo_mode = 1'b1;
      occ = 0;
      drain_pct = 40;
      force_full_pct = 10;
      for (int c = 0; c < 800; c++) begin
         if ($urandom_range(99) < 15) begin
            int l;
            l = int'($urandom_range(N - 1));
            if (lane_q[l].size() < 6) push(l, int'($urandom_range(1, 4)));
            apply();
         end
         step();
      end
      drain_pct = 100;
      force_full_pct = 0;
      run(150);
      chk("scoreboard empty", 64'(exp_q.size()), 64'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the write port of an asynchronous FIFO (fifo_asy, write side) between N requesters.
- Lives entirely in the FIFO write-clock domain.
- Grants one requester at a time for a bounded burst and forwards its words as registered en_w/data_w.
- Throttles against the FIFO's full_w and space_count, so no write is ever issued into a full FIFO.

Parameters:
- N, 4, number of requesters (2..8)
- DW, 32, data word width (matches FIFO data_w)
- BURST_MAX, 8, maximum words accepted per grant (1..255)
- CW, 8, width of the FIFO space_count input

Ports:
- clk  in  1  write-side clock (FIFO clk_w); all logic is on the rising edge
- rst  in  1  synchronous, active-high reset
- req  in  N  per-requester request; held high while the requester has a word on its data lane
- data_in  in  N*DW  flattened lanes; lane i = data_in[i*DW +: DW]
- ack  out  N  combinational; ack[i]=1 means lane i's word is accepted this cycle
- grant  out  N  registered one-hot owner; all zero when idle
- busy  out  1  registered; 1 while in state GRANT
- en_w  out  1  registered FIFO write enable
- data_w  out  DW  registered FIFO write data
- full_w  in  1  FIFO full flag
- space_count  in  CW  FIFO free entries; reflects a write one cycle after the edge that commits it

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, grant=0, busy=0, en_w=0, data_w=0, beat count=0, round-robin pointer=0. Reset mid-burst drops the current word; no ack in that cycle.
- State IDLE:
  - If any req, pick the first set req scanning from pointer upward, wrapping at N.
  - Next cycle: state=GRANT, grant=onehot(winner), beat count=0.
  - No ack is ever given in IDLE.
- Space check:
  - space_ok = !full_w && (space_count > en_w).
  - The registered write in flight is counted as already occupying one entry.
- State GRANT, owner g, each cycle:
  - accept = req[g] && space_ok.
  - ack[g] = accept; all other ack bits stay 0.
  - On accept: next en_w=1, next data_w=lane g, beat count +1.
  - Without accept: next en_w=0 and data_w holds its value.
- Grant release (leave GRANT, go to IDLE, pointer=(g+1) mod N) when either:
  - req[g]=0 while space_ok=1 (requester finished), or
  - an accept makes beat count reach BURST_MAX.
- No release on stall: if req[g]=1 and space_ok=0, the arbiter stays in GRANT and waits indefinitely.
- After a release, IDLE lasts exactly one cycle before the next grant (a fixed turnaround cycle).
- Latency: a word acked at cycle t appears on en_w/data_w at cycle t+1, for exactly one cycle per word.
- Throughput: one word per cycle within a burst.
- Fairness: a requester waits at most (N-1) bursts plus N turnaround cycles before it is granted.
- Simultaneous events:
  - The owner's req dropping in the same cycle as beat count reaching BURST_MAX is impossible, because acceptance needs req.
  - A req rising in the same cycle as a release is considered at the next IDLE evaluation.
- Arithmetic:
  - beat count is 8 bits; it never exceeds BURST_MAX.
  - The pointer is clog2(N) bits and wraps modulo N.
- Requester data must be stable while its req is high and it is not acked.

Test Plan:
- Single requester: req[0]=1 for 3 words (1001, 1002, 1003), space_count=16 → grant=0001 one cycle after req; ack[0] high 3 cycles; en_w pulses carry 1001, 1002, 1003 one cycle after each ack; busy returns to 0 after req drops.
- Round-robin: req=1111 continuous, BURST_MAX=8 → grants in order 0001, 0010, 0100, 1000, 0001; exactly 8 acks per grant; one idle cycle between grants.
- Backpressure: drive space_count=2 and hold it there (FIFO not draining), req[1] with 5 words → exactly 2 acks, then ack stays 0 while en_w=0; grant stays 0010; raising space_count to 16 resumes writes with words 3..5 in order and no loss.
- In-flight accounting: space_count=1, full_w=0 → one accept; the next cycle (space_count still 1, en_w=1) gives no accept; no write is issued when full_w=1.
- Reset mid-burst: rst=1 after 3 of 8 words → next cycle grant=0, en_w=0, busy=0, pointer=0; after release, req=0110 grants 0010 first.
- Fairness: req[0] always high, req[3] rises → req[3] is granted within one burst of req[0] plus one turnaround cycle.
